sipo_frame_ctrl: RTL and testbench
==================================

SIPO_FRAME_CTRL -- requirements
Module: sipo_frame_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, meaning the number of data bits per frame (legal range 2..32).
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in  input  1  serial data line; idle level 1.
REQ-005 en  input  1  bit strobe; `in` is sampled only in cycles where en=1.
REQ-006 out_ready  input  1  consumer accepts the held word in this cycle.
REQ-007 q  output  WIDTH  parallel word from the last good frame.
REQ-008 out_valid  output  1  q holds an unconsumed word.
REQ-009 busy  output  1  a frame is in progress (state is not IDLE).
REQ-010 frame_err  output  1  one-cycle pulse: the stop bit was sampled as 0.
REQ-011 overrun  output  1  one-cycle pulse: a good frame was dropped because the buffer was full.

Function
REQ-012 FSM states SHALL be IDLE, SHIFT and STOP.
- IDLE -> SHIFT when en=1 and in=0 (start bit).
- SHIFT -> STOP after WIDTH en-strobes have been sampled.
- STOP -> IDLE on the next en-strobe.
REQ-013 In SHIFT, each en-strobe SHALL shift `in` into bit 0 of an internal shift register, with older bits moving toward the MSB, so the first data bit ends in bit WIDTH-1.
REQ-014 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide, clear on entry to SHIFT, and increment only on en-strobes.
REQ-015 Cycles with en=0 SHALL leave the FSM, counter and shift register unchanged.
REQ-016 A stop bit of 1 with out_valid=0 SHALL load q from the shift register and set out_valid on the next edge.
- Latency: 1 cycle after the stop-bit strobe.
REQ-017 A stop bit of 0 SHALL pulse frame_err for 1 cycle, discard the frame, and leave q and out_valid unchanged.
REQ-018 out_valid SHALL clear on the edge where out_valid=1 and out_ready=1.
- q SHALL hold its value until the next load.
REQ-019 Good stop bit while out_valid=1 and out_ready=0:
- overrun SHALL pulse for 1 cycle;
- the new frame SHALL be dropped;
- q and out_valid SHALL be kept.
REQ-020 Good stop bit while out_valid=1 and out_ready=1 in the same cycle:
- q SHALL load the new word;
- out_valid SHALL stay 1;
- overrun SHALL NOT pulse.
REQ-021 en=1 with in=1 in IDLE SHALL be ignored (line idle).
REQ-022 After STOP, the FSM SHALL return to IDLE.
- A start bit SHALL NOT be accepted in the same en-strobe as the stop bit.
- A start bit on the next en-strobe SHALL be accepted.
REQ-023 busy SHALL equal (state != IDLE) combinationally from the state register.

Reset
REQ-024 On rst=1 at a clock edge, the following SHALL clear in that same edge, regardless of state or en:
- state=IDLE;
- counter=0, shift register=0;
- q=0, out_valid=0, busy=0, frame_err=0, overrun=0.
REQ-025 Reset mid-frame SHALL abandon the partial frame with no frame_err or overrun pulse.
REQ-026 Reset SHALL take priority over every other event in the same cycle.

Structure
REQ-027 Shared package sipo_pkg SHALL hold:
- the FSM state encoding constants (IDLE=2'd0, SHIFT=2'd1, STOP=2'd2);
- the default WIDTH constant.
REQ-028 The shift register SHALL be a sub-module sipo_shreg, with:
- parameter WIDTH;
- ports clk, rst, shift_en, in, q[WIDTH-1:0];
- synchronous active-high reset.
REQ-029 All other logic (FSM, counter, output buffer, pulses) SHALL reside in sipo_frame_ctrl.

Verification (WIDTH=8, en=1 every cycle unless stated)
REQ-030 Good frame: start 0, data 1,0,1,0,0,1,0,1, stop 1 -> q=8'hA5 and out_valid=1 one cycle after the stop strobe; busy=1 from the cycle after the start strobe until return to IDLE.
REQ-031 Bad stop: frame 8'h3C with stop bit 0 -> frame_err pulses once; q and out_valid unchanged.
REQ-032 Overrun: frame 8'h11 left unconsumed (out_ready=0), then frame 8'h22 -> overrun pulses once; q=8'h11 remains.
REQ-033 Same-cycle accept: out_valid=1 with q=8'h11 and out_ready=1 on the stop strobe of frame 8'h22 -> q=8'h22, out_valid=1, no overrun.
REQ-034 Sparse strobes: en=1 only every 4th cycle, frame 8'h5A -> q=8'h5A; no state change in en=0 cycles.
REQ-035 Reset mid-frame: rst after 4 data bits -> all outputs 0 next cycle; a following frame 8'hC3 is received correctly.

Source files
------------

// File: rtl/sipo_pkg.sv
// rtl/sipo_pkg.sv - shared constants and FSM state encoding for the SIPO frame receiver
package sipo_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      STOP  = 2'd2
   } state_e;

endpackage

// File: rtl/sipo_frame_ctrl_if.sv
// rtl/sipo_frame_ctrl_if.sv - held-word output handshake between receiver and consumer
interface sipo_frame_ctrl_if
   import sipo_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);
   logic [WIDTH-1:0] q;
   logic             out_valid;
   logic             out_ready;

   modport master (output q, output out_valid, input  out_ready);
   modport slave  (input  q, input  out_valid, output out_ready);
endinterface

// File: rtl/sipo_shreg.sv
// rtl/sipo_shreg.sv - serial-in shift register, newest bit enters at bit 0
module sipo_shreg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             shift_en,
   input  logic             in,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] shreg_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         shreg_q <= '0;
      end else if (shift_en) begin
         shreg_q <= {shreg_q[WIDTH-2:0], in};
      end
   end

   assign q = shreg_q;
endmodule

// File: rtl/sipo_frame_ctrl.sv
// rtl/sipo_frame_ctrl.sv - strobed serial frame receiver with one-word output buffer
module sipo_frame_ctrl
   import sipo_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in,
   input  logic             en,
   input  logic             out_ready,
   output logic [WIDTH-1:0] q,
   output logic             out_valid,
   output logic             busy,
   output logic             frame_err,
   output logic             overrun
);
   localparam int            CW       = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_e           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] q_q;
   logic             valid_q;
   logic             ferr_q;
   logic             ovr_q;
   logic             shift_en;
   logic             stop_strobe;
   logic             load;
   logic             consume;

   assign shift_en    = en && (state_q == SHIFT);
   assign stop_strobe = en && (state_q == STOP);
   // A consumer accepting in the same cycle frees the buffer for the new word.
   assign load        = stop_strobe && in && (!valid_q || out_ready);
   assign consume     = valid_q && out_ready;

   sipo_shreg #(.WIDTH(WIDTH)) u_shreg (
      .clk      (clk),
      .rst      (rst),
      .shift_en (shift_en),
      .in       (in),
      .q        (shreg)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         q_q     <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         ferr_q <= 1'b0;
         ovr_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (en && !in) begin
                  state_q <= SHIFT;
                  cnt_q   <= '0;
               end
            end
            SHIFT: begin
               if (en) begin
                  cnt_q <= cnt_q + CW'(1);
                  if (cnt_q == LAST_BIT) begin
                     state_q <= STOP;
                  end
               end
            end
            STOP: begin
               // Always back to IDLE: a start bit cannot share the stop strobe.
               if (en) begin
                  state_q <= IDLE;
                  if (!in) begin
                     ferr_q <= 1'b1;
                  end else if (!load) begin
                     ovr_q <= 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase

         if (load) begin
            q_q     <= shreg;
            valid_q <= 1'b1;
         end else if (consume) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign q         = q_q;
   assign out_valid = valid_q;
   assign busy      = (state_q != IDLE);
   assign frame_err = ferr_q;
   assign overrun   = ovr_q;
endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// tb/tb_sipo_frame_ctrl.sv - self-checking bench for sipo_frame_ctrl
module tb_sipo_frame_ctrl;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst_r = 1'b1;
   logic en_r = 1'b0;
   logic in_r = 1'b1;
   logic rdy_r = 1'b0;
   logic busy, frame_err, overrun;
   int   errors = 0;
   int   checks = 0;
   bit   check_on = 1'b0;

   sipo_frame_ctrl_if #(.WIDTH(W)) ob ();
   assign ob.out_ready = rdy_r;

   sipo_frame_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst_r),
      .in        (in_r),
      .en        (en_r),
      .out_ready (ob.out_ready),
      .q         (ob.q),
      .out_valid (ob.out_valid),
      .busy      (busy),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   // Reference model: phase -1 = waiting for start, 0..W-1 = data bits taken, W = expecting stop.
   int         m_phase = -1;
   int         m_acc   = 0;
   logic [W-1:0] m_q   = '0;
   logic       m_valid = 1'b0;
   logic       m_busy  = 1'b0;
   logic       m_ferr  = 1'b0;
   logic       m_ovr   = 1'b0;

   always @(posedge clk) begin
      logic accept_now;
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
      if (rst_r) begin
         m_phase = -1;
         m_acc   = 0;
         m_q     = '0;
         m_valid = 1'b0;
      end else begin
         accept_now = m_valid && rdy_r;
         if (en_r) begin
            if (m_phase < 0) begin
               if (!in_r) begin
                  m_phase = 0;
                  m_acc   = 0;
               end
            end else if (m_phase < W) begin
               m_acc   = m_acc * 2 + int'(in_r);
               m_phase = m_phase + 1;
            end else begin
               m_phase = -1;
               if (!in_r) begin
                  m_ferr = 1'b1;
               end else if (!m_valid || rdy_r) begin
                  m_q        = m_acc[W-1:0];
                  m_valid    = 1'b1;
                  accept_now = 1'b0;
               end else begin
                  m_ovr = 1'b1;
               end
            end
         end
         if (accept_now) m_valid = 1'b0;
      end
      m_busy = (m_phase >= 0);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (check_on) begin
         chk("model q", 32'(ob.q), 32'(m_q));
         chk("model out_valid", 32'(ob.out_valid), 32'(m_valid));
         chk("model busy", 32'(busy), 32'(m_busy));
         chk("model frame_err", 32'(frame_err), 32'(m_ferr));
         chk("model overrun", 32'(overrun), 32'(m_ovr));
      end
   end

   task automatic step(input logic e, input logic b, input logic r);
      @(negedge clk);
      rst_r = 1'b0;
      en_r  = e;
      in_r  = b;
      rdy_r = r;
   endtask

   task automatic send_frame(input logic [W-1:0] w, input logic stop, input logic rdy_stop, input int gap);
      step(1'b1, 1'b0, 1'b0);
      repeat (gap) step(1'b0, 1'b0, 1'b0);
      for (int i = W - 1; i >= 0; i--) begin
         step(1'b1, w[i], 1'b0);
         repeat (gap) step(1'b0, 1'b0, 1'b0);
      end
      step(1'b1, stop, rdy_stop);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check_on = 1'b1;
      chk("reset q", 32'(ob.q), 32'h0);
      chk("reset out_valid", 32'(ob.out_valid), 32'h0);
      chk("reset busy", 32'(busy), 32'h0);

      // Idle line strobes must not start a frame.
      repeat (3) step(1'b1, 1'b1, 1'b0);
      chk("idle busy", 32'(busy), 32'h0);

      send_frame(8'hA5, 1'b1, 1'b0, 0);
      step(1'b0, 1'b1, 1'b0);
      chk("A5 q", 32'(ob.q), 32'hA5);
      chk("A5 valid", 32'(ob.out_valid), 32'h1);
      chk("A5 busy", 32'(busy), 32'h0);

      step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b0);
      chk("consume valid", 32'(ob.out_valid), 32'h0);
      chk("consume q hold", 32'(ob.q), 32'hA5);

      send_frame(8'h3C, 1'b0, 1'b0, 0);
      step(1'b0, 1'b1, 1'b0);
      chk("bad stop frame_err", 32'(frame_err), 32'h1);
      chk("bad stop q", 32'(ob.q), 32'hA5);
      chk("bad stop valid", 32'(ob.out_valid), 32'h0);
      step(1'b0, 1'b1, 1'b0);
      chk("frame_err one cycle", 32'(frame_err), 32'h0);

      send_frame(8'h11, 1'b1, 1'b0, 0);
      send_frame(8'h22, 1'b1, 1'b0, 0);
      step(1'b0, 1'b1, 1'b0);
      chk("overrun pulse", 32'(overrun), 32'h1);
      chk("overrun q kept", 32'(ob.q), 32'h11);
      chk("overrun valid kept", 32'(ob.out_valid), 32'h1);

      send_frame(8'h22, 1'b1, 1'b1, 0);
      step(1'b0, 1'b1, 1'b0);
      chk("same-cycle q", 32'(ob.q), 32'h22);
      chk("same-cycle valid", 32'(ob.out_valid), 32'h1);
      chk("same-cycle overrun", 32'(overrun), 32'h0);

      step(1'b0, 1'b1, 1'b1);
      send_frame(8'h5A, 1'b1, 1'b0, 3);
      step(1'b0, 1'b1, 1'b1);
      chk("sparse q", 32'(ob.q), 32'h5A);

      // Bad stop followed at once by a start bit on the very next strobe.
      send_frame(8'h0F, 1'b0, 1'b0, 0);
      send_frame(8'h96, 1'b1, 1'b0, 0);
      step(1'b0, 1'b1, 1'b0);
      chk("back-to-back q", 32'(ob.q), 32'h96);

      step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b1, i[0], 1'b0);
      @(negedge clk);
      rst_r = 1'b1;
      en_r  = 1'b1;
      in_r  = 1'b0;
      step(1'b0, 1'b1, 1'b0);
      chk("midreset q", 32'(ob.q), 32'h0);
      chk("midreset valid", 32'(ob.out_valid), 32'h0);
      chk("midreset busy", 32'(busy), 32'h0);
      chk("midreset pulses", {30'h0, frame_err, overrun}, 32'h0);

      send_frame(8'hC3, 1'b1, 1'b0, 0);
      step(1'b0, 1'b1, 1'b0);
      chk("after reset q", 32'(ob.q), 32'hC3);
      chk("after reset valid", 32'(ob.out_valid), 32'h1);

      repeat (2) step(1'b0, 1'b1, 1'b0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
